gate_sweep_checker: RTL and testbench

//  Self-checking, synthesisable successor to the hand-written switch-level gate benches.

---
 rtl/gate_sweep_pkg.sv | 25 ++
 rtl/gate_ref_model.sv | 31 +++
 rtl/gate_sweep_checker.sv | 146 ++++++++++++++
 tb/tb_gate_sweep_checker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg
//   Shared types for the gate sweep checker and the reusable gate reference model.
//   gate_mode_e   : reference gate function selected by a 3-bit mode code.
//   sweep_state_e : sweep controller states (2 bits).
package gate_sweep_pkg;

   typedef enum logic [2:0] {
      MODE_OR   = 3'd0,
      MODE_NOR  = 3'd1,
      MODE_AND  = 3'd2,
      MODE_NAND = 3'd3,
      MODE_XOR  = 3'd4,
      MODE_XNOR = 3'd5,
      MODE_BUF  = 3'd6,
      MODE_INV  = 3'd7
   } gate_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } sweep_state_e;

endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model
//   Combinational golden reference for an N_IN-input logic gate.
//   stim : input vector applied to the gate
//   mode : gate function (BUF/INV use stim[0] only)
//   exp  : expected gate output
module gate_ref_model
   import gate_sweep_pkg::*;
#(
   parameter int unsigned N_IN = 2
) (
   input  logic [N_IN-1:0] stim,
   input  gate_mode_e      mode,
   output logic            exp
);

   always_comb begin
      exp = 1'b0;
      unique case (mode)
         MODE_OR:   exp =  (|stim);
         MODE_NOR:  exp = ~(|stim);
         MODE_AND:  exp =  (&stim);
         MODE_NAND: exp = ~(&stim);
         MODE_XOR:  exp =  (^stim);
         MODE_XNOR: exp = ~(^stim);
         MODE_BUF:  exp =  stim[0];
         MODE_INV:  exp = ~stim[0];
         default:   exp = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Sweeps all 2^N_IN input vectors of a gate under test, holds each vector for
//   SETTLE cycles, samples the gate output and compares it with gate_ref_model.
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   start       : begin a sweep (accepted in IDLE and DONE only)
//   mode        : reference function, latched on the accepting start edge
//   dut_out     : output of the gate under test
//   stim        : vector driven onto the gate inputs
//   busy / done : sweep in progress / sweep finished, results held
//   pass        : valid with done, 1 iff no mismatches were seen
//   err_count   : saturating mismatch count for this sweep
//   fail_valid  : a mismatch has been captured; first_fail holds its vector
module gate_sweep_checker
   import gate_sweep_pkg::*;
#(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned SETTLE = 4,
   parameter int unsigned ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic             dut_out,
   output logic [N_IN-1:0]  stim,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_valid,
   output logic [N_IN-1:0]  first_fail
);

   localparam int unsigned     CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   sweep_state_e     state_q, state_d;
   gate_mode_e       mode_q, mode_d;
   logic [N_IN-1:0]  stim_q, stim_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             fail_valid_q, fail_valid_d;
   logic [N_IN-1:0]  first_fail_q, first_fail_d;
   logic             pass_q, pass_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic ref_exp;
   logic mismatch;

   gate_ref_model #(.N_IN(N_IN)) u_ref (
      .stim (stim_q),
      .mode (mode_q),
      .exp  (ref_exp)
   );

   // Case inequality so an X/Z gate output is reported as a mismatch in simulation.
   assign mismatch = (dut_out !== ref_exp);

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      stim_d       = stim_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               mode_d       = gate_mode_e'(mode);
               stim_d       = '0;
               cnt_d        = '0;
               err_d        = '0;
               fail_valid_d = 1'b0;
               first_fail_d = '0;
               pass_d       = 1'b0;
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (mismatch) begin
               if (!(&err_q)) err_d = err_q + ERR_W'(1);
               if (!fail_valid_q) begin
                  first_fail_d = stim_q;
                  fail_valid_d = 1'b1;
               end
            end
            if (&stim_q) begin
               // Last vector: stim holds, pass also covers this final sample.
               pass_d  = (err_q == '0) && !mismatch;
               state_d = ST_DONE;
            end else begin
               stim_d  = stim_q + N_IN'(1);
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_OR;
         stim_q       <= '0;
         cnt_q        <= '0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         first_fail_q <= '0;
         pass_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         stim_q       <= stim_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign stim       = stim_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fail_valid_q;
   assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker
//   Three checker instances: A (N_IN=2, ERR_W=8), B (N_IN=3, ERR_W=8),
//   C (N_IN=2, ERR_W=1), all SETTLE=4. A behavioural gate stands in for the
//   CMOS gate model; it can be any gate function, tied low, or faulted on one vector.
module tb_gate_sweep_checker;

   localparam int SPV = 5; // edges per vector: SETTLE + 1

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic [2:0]  mode_r;
   int          sel;
   int          dut_kind;   // 0..7 gate function, 8 = tied low
   logic        fault_en;
   logic [15:0] fault_vec;

   logic       start_a, start_b, start_c;
   logic       dut_out_a, dut_out_b, dut_out_c;
   logic [1:0] stim_a, ff_a;
   logic [2:0] stim_b, ff_b;
   logic [1:0] stim_c, ff_c;
   logic [7:0] err_a, err_b;
   logic [0:0] err_c;
   logic busy_a, done_a, pass_a, fv_a;
   logic busy_b, done_b, pass_b, fv_b;
   logic busy_c, done_c, pass_c, fv_c;

   logic [15:0] obs_stim, obs_ff;
   logic [7:0]  obs_err;
   logic        obs_busy, obs_done, obs_pass, obs_fv;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int err;
      int ff;
      int fv;
      int pass;
      int lat;
   } exp_t;
   exp_t sb[$];

   function automatic logic gate_fn(input int kind, input logic [15:0] v, input int n);
      logic [31:0] m32;
      logic [15:0] mask;
      m32  = (32'h1 << n) - 32'h1;
      mask = m32[15:0];
      case (kind)
         0:       return  (|(v & mask));
         1:       return ~(|(v & mask));
         2:       return  (&(v | ~mask));
         3:       return ~(&(v | ~mask));
         4:       return  (^(v & mask));
         5:       return ~(^(v & mask));
         6:       return  v[0];
         7:       return ~v[0];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic dut_model(input int kind, input logic fen, input logic [15:0] fvec,
                                      input logic [15:0] v, input int n);
      return gate_fn(kind, v, n) ^ (fen && (v == fvec));
   endfunction

   assign start_a = start && (sel == 0);
   assign start_b = start && (sel == 1);
   assign start_c = start && (sel == 2);
   assign dut_out_a = dut_model(dut_kind, fault_en, fault_vec, 16'(stim_a), 2);
   assign dut_out_b = dut_model(dut_kind, fault_en, fault_vec, 16'(stim_b), 3);
   assign dut_out_c = dut_model(dut_kind, fault_en, fault_vec, 16'(stim_c), 2);

   gate_sweep_checker #(.N_IN(2), .SETTLE(4), .ERR_W(8)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode_r), .dut_out(dut_out_a),
      .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .fail_valid(fv_a), .first_fail(ff_a));

   gate_sweep_checker #(.N_IN(3), .SETTLE(4), .ERR_W(8)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode_r), .dut_out(dut_out_b),
      .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .fail_valid(fv_b), .first_fail(ff_b));

   gate_sweep_checker #(.N_IN(2), .SETTLE(4), .ERR_W(1)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_c), .mode(mode_r), .dut_out(dut_out_c),
      .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c),
      .err_count(err_c), .fail_valid(fv_c), .first_fail(ff_c));

   always_comb begin
      case (sel)
         1: begin
            obs_stim = 16'(stim_b); obs_ff = 16'(ff_b); obs_err = err_b;
            obs_busy = busy_b; obs_done = done_b; obs_pass = pass_b; obs_fv = fv_b;
         end
         2: begin
            obs_stim = 16'(stim_c); obs_ff = 16'(ff_c); obs_err = 8'(err_c);
            obs_busy = busy_c; obs_done = done_c; obs_pass = pass_c; obs_fv = fv_c;
         end
         default: begin
            obs_stim = 16'(stim_a); obs_ff = 16'(ff_a); obs_err = err_a;
            obs_busy = busy_a; obs_done = done_a; obs_pass = pass_a; obs_fv = fv_a;
         end
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset(input string pfx);
      check_eq({pfx, "_stim"}, 32'(obs_stim), 0);
      check_eq({pfx, "_busy"}, 32'(obs_busy), 0);
      check_eq({pfx, "_done"}, 32'(obs_done), 0);
      check_eq({pfx, "_pass"}, 32'(obs_pass), 0);
      check_eq({pfx, "_err"},  32'(obs_err),  0);
      check_eq({pfx, "_fv"},   32'(obs_fv),   0);
      check_eq({pfx, "_ff"},   32'(obs_ff),   0);
   endtask

   task automatic run_sweep(input int s, input int n, input int ew, input logic [2:0] m,
                            input int kind, input bit busy_pulses);
      exp_t x;
      int   nvec, maxe, e;
      bit   got, any_mm;
      sel      = s;
      dut_kind = kind;
      nvec     = 1 << n;
      maxe     = (1 << ew) - 1;
      x.err = 0; x.ff = 0; x.fv = 0; any_mm = 0;
      for (int v = 0; v < nvec; v++) begin
         if (dut_model(kind, fault_en, fault_vec, 16'(v), n) !== gate_fn(int'(m), 16'(v), n)) begin
            any_mm = 1;
            if (x.err < maxe) x.err++;
            if (x.fv == 0) begin
               x.ff = v;
               x.fv = 1;
            end
         end
      end
      x.pass = any_mm ? 0 : 1;
      x.lat  = nvec * SPV;
      sb.push_back(x);

      @(negedge clk);
      mode_r = m;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      mode_r = 3'($urandom_range(0, 7));
      check_eq("acc_busy", 32'(obs_busy), 1);
      check_eq("acc_done", 32'(obs_done), 0);
      check_eq("clr_err",  32'(obs_err),  0);
      check_eq("clr_fv",   32'(obs_fv),   0);
      check_eq("clr_ff",   32'(obs_ff),   0);
      check_eq("clr_pass", 32'(obs_pass), 0);
      check_eq("acc_stim", 32'(obs_stim), 0);

      e   = 0;
      got = 0;
      while (!got && e < x.lat + 20) begin
         @(posedge clk);
         #1;
         e++;
         if (busy_pulses && e == 7) begin
            start  = 1'b1;
            mode_r = 3'($urandom_range(0, 7));
         end
         if (busy_pulses && e == 8) start = 1'b0;
         if (obs_done) got = 1;
         else          check_eq("stim_seq", 32'(obs_stim), 32'(e / SPV));
      end
      start = 1'b0;
      if (!got) check_eq("done_timeout", 0, 1);
      else      check_eq("done_lat", 32'(e), 32'(x.lat));

      x = sb.pop_front();
      check_eq("res_err",  32'(obs_err),  32'(x.err));
      check_eq("res_ff",   32'(obs_ff),   32'(x.ff));
      check_eq("res_fv",   32'(obs_fv),   32'(x.fv));
      check_eq("res_pass", 32'(obs_pass), 32'(x.pass));
      check_eq("res_busy", 32'(obs_busy), 0);
      check_eq("res_stim", 32'(obs_stim), 32'(nvec - 1));

      repeat (3) @(posedge clk);
      #1;
      check_eq("hold_done", 32'(obs_done), 1);
      check_eq("hold_err",  32'(obs_err),  32'(x.err));
      check_eq("hold_pass", 32'(obs_pass), 32'(x.pass));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1; start = 1'b0; mode_r = '0; sel = 0;
      dut_kind = 0; fault_en = 1'b0; fault_vec = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check_reset("por");
      end
      @(negedge clk);
      rst = 1'b0;

      // OR gate, OR reference: clean sweep
      run_sweep(0, 2, 8, 3'd0, 0, 0);
      // AND reference against OR gate: mismatches at 1 and 2
      run_sweep(0, 2, 8, 3'd2, 0, 0);
      // from DONE with stale failures, NOR reference against NOR gate
      run_sweep(0, 2, 8, 3'd1, 1, 0);

      // reset mid-sweep once stim reaches 2 (after a mismatch at stim 1)
      sel = 0; dut_kind = 0;
      @(negedge clk);
      mode_r = 3'd2;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k = 0;
      while (obs_stim != 16'd2 && k < 30) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_eq("mid_stim_reached", 32'(obs_stim), 2);
      check_eq("mid_fv", 32'(obs_fv), 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      run_sweep(0, 2, 8, 3'd0, 0, 0);

      // 3-input XOR with one faulty vector
      fault_en = 1'b1; fault_vec = 16'h0006;
      run_sweep(1, 3, 8, 3'd4, 4, 0);
      fault_en = 1'b0;

      // 1-bit saturating counter, gate tied low, XNOR reference, start pulses while busy
      run_sweep(2, 2, 1, 3'd5, 8, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
